// File: rtl/mssd_serial_tx.sv
// Serial frame transmitter: START bit, 8-bit header {len, port}, len payload bytes MSB first, STOP bit.
// Define MSSD_TX_GUARD_EN to insert two idle-high GUARD cycles between STOP and IDLE.
module mssd_serial_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] port,
  input  logic [5:0] len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serOut,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, START, HDR, DATA, STOP, GUARD} state_t;

  state_t     state;
  logic [7:0] shift_reg;
  logic [7:0] hold_byte;
  logic       hold_full;
  logic [2:0] bit_cnt;
  logic [5:0] len_r;
  logic [5:0] acc_cnt;
  logic [5:0] bytes_left;
`ifdef MSSD_TX_GUARD_EN
  logic       guard_cnt;
`endif

  logic       xfer;
  logic       final_bit;
  logic       load_pt;
  logic [7:0] next_byte;

  assign data_ready = busy && !hold_full && (acc_cnt < len_r);
  assign xfer       = data_valid && data_ready;
  assign final_bit  = (bit_cnt == 3'd7);
  assign load_pt    = final_bit && ((state == HDR) || ((state == DATA) && (bytes_left != 6'd0)));
  // A byte handed over in the load cycle itself bypasses the holding register.
  assign next_byte  = hold_full ? hold_byte : (xfer ? data_in : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= 8'h00;
      hold_byte  <= 8'h00;
      hold_full  <= 1'b0;
      bit_cnt    <= 3'd0;
      len_r      <= 6'd0;
      acc_cnt    <= 6'd0;
      bytes_left <= 6'd0;
      serOut     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
`ifdef MSSD_TX_GUARD_EN
      guard_cnt  <= 1'b0;
`endif
    end else begin
      if (xfer)
        acc_cnt <= acc_cnt + 6'd1;

      if (load_pt)
        hold_full <= 1'b0;
      else if (xfer) begin
        hold_full <= 1'b1;
        hold_byte <= data_in;
      end

      case (state)
        IDLE: begin
          if (start && (len != 6'd0)) begin
            state      <= START;
            busy       <= 1'b1;
            serOut     <= 1'b0;
            shift_reg  <= {len, port};
            len_r      <= len;
            bytes_left <= len;
            acc_cnt    <= 6'd0;
            hold_full  <= 1'b0;
            underrun   <= 1'b0;
            bit_cnt    <= 3'd0;
          end
        end

        START: begin
          state     <= HDR;
          serOut    <= shift_reg[7];
          shift_reg <= {shift_reg[6:0], 1'b0};
        end

        HDR, DATA: begin
          if (final_bit) begin
            bit_cnt <= 3'd0;
            if (load_pt) begin
              state      <= DATA;
              serOut     <= next_byte[7];
              shift_reg  <= {next_byte[6:0], 1'b0};
              bytes_left <= bytes_left - 6'd1;
              if (!hold_full && !xfer)
                underrun <= 1'b1;
            end else begin
              state  <= STOP;
              serOut <= 1'b1;
              done   <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            serOut    <= shift_reg[7];
            shift_reg <= {shift_reg[6:0], 1'b0};
          end
        end

        STOP: begin
          done   <= 1'b0;
          serOut <= 1'b1;
`ifdef MSSD_TX_GUARD_EN
          state     <= GUARD;
          guard_cnt <= 1'b0;
`else
          state  <= IDLE;
          busy   <= 1'b0;
`endif
        end

`ifdef MSSD_TX_GUARD_EN
        GUARD: begin
          serOut <= 1'b1;
          if (guard_cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            guard_cnt <= 1'b1;
          end
        end
`endif

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          serOut <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mssd_serial_tx.sv
// Self-checking bench for mssd_serial_tx: frame-level reference model plus directed frames.
// Honours MSSD_TX_GUARD_EN the same way the design does.
module tb_mssd_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] port = 2'b00;
  logic [5:0] len = 6'd0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       serOut;
  logic       busy;
  logic       done;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  mssd_serial_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .port       (port),
    .len        (len),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .serOut     (serOut),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue entry per expected cycle of {serOut, busy, done}.
  typedef struct packed {logic ser; logic bsy; logic dn;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  int         slots = 0;
  int         to_load = 0;
  int         xfer_cnt = 0;
  logic       exp_underrun = 1'b0;

  function automatic exp_t mk(input logic s, input logic b, input logic d);
    exp_t e;
    e.ser = s; e.bsy = b; e.dn = d;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit         idle_now;
    logic [7:0] b;
    logic [7:0] hdr;
    if (rst) begin
      exp_q.delete();
      byte_q.delete();
      slots        = 0;
      to_load      = 0;
      exp_underrun = 1'b0;
    end else begin
      idle_now = (exp_q.size() == 0);
      if (data_valid && data_ready) begin
        byte_q.push_back(data_in);
        xfer_cnt++;
      end
      if (!idle_now)
        void'(exp_q.pop_front());
      if (slots > 0) begin
        to_load--;
        if (to_load == 0) begin
          if (byte_q.size() > 0)
            b = byte_q.pop_front();
          else begin
            b = 8'h00;
            exp_underrun = 1'b1;
          end
          for (int i = 7; i >= 0; i--)
            exp_q.push_back(mk(b[i], 1'b1, 1'b0));
          slots--;
          if (slots == 0) begin
            exp_q.push_back(mk(1'b1, 1'b1, 1'b1));
`ifdef MSSD_TX_GUARD_EN
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0));
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0));
`endif
          end else begin
            to_load = 8;
          end
        end
      end
      if (idle_now && start && (len != 6'd0)) begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
        hdr = {len, port};
        for (int i = 7; i >= 0; i--)
          exp_q.push_back(mk(hdr[i], 1'b1, 1'b0));
        slots        = int'(len);
        to_load      = 9;
        exp_underrun = 1'b0;
        xfer_cnt     = 0;
        byte_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = (exp_q.size() > 0) ? exp_q[0] : mk(1'b1, 1'b0, 1'b0);
    checkOutput("serOut", 64'(serOut), 64'(e.ser));
    checkOutput("busy", 64'(busy), 64'(e.bsy));
    checkOutput("done", 64'(done), 64'(e.dn));
    checkOutput("underrun", 64'(underrun), 64'(exp_underrun));
    if (exp_q.size() == 0)
      checkOutput("ready_idle", 64'(data_ready), 64'd0);
  end

  // Frame recorder for the literal expectations.
  int   cyc = 0;
  logic prev_busy = 1'b0;
  bit   cap_q[$];
  int   done_idx = -1;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   gap = 0;

  always @(negedge clk) begin
    cyc++;
    if (busy && !prev_busy) begin
      cap_q.delete();
      done_cnt = 0;
      done_idx = -1;
      if (last_done_cyc > 0)
        gap = cyc - last_done_cyc;
    end
    if (busy)
      cap_q.push_back(serOut);
    if (done) begin
      done_cnt++;
      done_idx = cap_q.size() - 1;
      last_done_cyc = cyc;
    end
    prev_busy = busy;
  end

  function automatic logic [63:0] capBits(input int s, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = s; i < s + n; i++)
      v = {v[62:0], (i < cap_q.size()) ? logic'(cap_q[i]) : 1'bx};
    return v;
  endfunction

  logic [7:0] stim_bytes [0:63];
  bit         keep_valid = 1'b0;

  task automatic feedBytes(input int nb, input int budget);
    int i;
    i = 0;
    for (int t = 0; (t < budget) && (i < nb); t++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = stim_bytes[i];
      if (data_ready)
        i++;
    end
    @(negedge clk);
    if (keep_valid)
      data_in = 8'hEE;
    else
      data_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] p, input logic [5:0] l, input int nb,
                               input int dropAfter, input int cycles);
    @(negedge clk);
    port  = p;
    len   = l;
    start = 1'b1;
    fork
      feedBytes(nb, dropAfter + cycles);
      begin
        repeat (dropAfter) @(negedge clk);
        start = 1'b0;
        repeat (cycles) @(negedge clk);
      end
    join
  endtask

  logic [25:0] frame26;

  initial begin
    $display("[TB] mssd_serial_tx bench start");
    repeat (3) @(negedge clk);
    checkOutput("rst_serOut", 64'(serOut), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ready", 64'(data_ready), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_underrun", 64'(underrun), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-byte frame to port 2.
    stim_bytes[0] = 8'hA5;
    applyStimulus(2'b10, 6'd1, 1, 1, 24);
    checkOutput("f1_bits", capBits(0, 18), 64'(18'b0_000001_10_10100101_1));
    checkOutput("f1_done_idx", 64'(done_idx), 64'd17);
    checkOutput("f1_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("f1_underrun", 64'(underrun), 64'd0);

    // Three bytes with data_valid held high throughout.
    stim_bytes[0] = 8'h01; stim_bytes[1] = 8'hFF; stim_bytes[2] = 8'h3C;
    keep_valid = 1'b1;
    applyStimulus(2'b01, 6'd3, 3, 1, 40);
    checkOutput("f3_xfers", 64'(xfer_cnt), 64'd3);
    keep_valid = 1'b0;
    data_valid = 1'b0;
    checkOutput("f3_data", capBits(9, 24), 64'h01FF3C);
    checkOutput("f3_len", 64'(done_idx + 1), 64'd34);

    // Underrun: second byte never supplied.
    stim_bytes[0] = 8'h81;
    applyStimulus(2'b11, 6'd2, 1, 1, 30);
    checkOutput("ur_data", capBits(9, 16), 64'h8100);
    checkOutput("ur_flag", 64'(underrun), 64'd1);

    // len == 0 request is ignored and leaves the sticky flag alone.
    applyStimulus(2'b00, 6'd0, 0, 3, 4);
    checkOutput("z_busy", 64'(busy), 64'd0);
    checkOutput("z_serOut", 64'(serOut), 64'd1);
    checkOutput("z_ready", 64'(data_ready), 64'd0);
    checkOutput("z_underrun", 64'(underrun), 64'd1);

    stim_bytes[0] = 8'h5A;
    applyStimulus(2'b00, 6'd1, 1, 1, 24);
    checkOutput("ur_cleared", 64'(underrun), 64'd0);
    checkOutput("f5a_data", capBits(9, 8), 64'h5A);

    // Reset in DATA cycle 5 of a two-byte frame, then a clean retry.
    stim_bytes[0] = 8'h12; stim_bytes[1] = 8'h34;
    fork
      applyStimulus(2'b01, 6'd2, 2, 1, 20);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (13) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_serOut", 64'(serOut), 64'd1);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_ready", 64'(data_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    applyStimulus(2'b01, 6'd2, 2, 1, 32);
    frame26 = {1'b0, 6'd2, 2'b01, 8'h12, 8'h34, 1'b1};
    checkOutput("retry_bits", capBits(0, 26), 64'(frame26));
    checkOutput("retry_len", 64'(done_idx + 1), 64'd26);

    // Back-to-back frames with start held high.
    stim_bytes[0] = 8'hC3; stim_bytes[1] = 8'h3C;
    applyStimulus(2'b00, 6'd1, 2, 25, 25);
`ifdef MSSD_TX_GUARD_EN
    checkOutput("b2b_gap", 64'(gap), 64'd4);
`else
    checkOutput("b2b_gap", 64'(gap), 64'd2);
`endif
    checkOutput("b2b_data", capBits(9, 8), 64'h3C);
    checkOutput("b2b_idle", 64'(busy), 64'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mssd_serial_tx.md
MSSD_SERIAL_TX -- requirements
Module: mssd_serial_tx

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have start, input, 1, frame request, sampled only in IDLE.
REQ-004 SHALL have port, input, 2, destination port number, captured on start acceptance.
REQ-005 SHALL have len, input, 6, payload length in bytes (1..63), captured on start acceptance.
REQ-006 SHALL have data_in, input, 8, payload byte.
REQ-007 SHALL have data_valid, input, 1, data_in valid.
REQ-008 SHALL have data_ready, output, 1, transmitter can accept a payload byte; a transfer occurs when data_valid && data_ready.
REQ-009 SHALL have serOut, output, 1, serial line, idle high.
REQ-010 SHALL have busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have done, output, 1, one-cycle pulse during the stop-bit cycle.
REQ-012 SHALL have underrun, output, 1, sticky flag, cleared on the next start acceptance.

Function
REQ-013 SHALL implement states IDLE, START, HDR, DATA, STOP (plus GUARD per REQ-027); registered outputs; serOut driven from a register.
REQ-014 SHALL accept a frame when state==IDLE, start==1 and len!=0; start with len==0 SHALL be ignored (stay IDLE, busy low).
REQ-015 SHALL spend exactly 1 cycle in START with serOut=0, starting the cycle after acceptance.
REQ-016 SHALL spend exactly 8 cycles in HDR, transmitting len[5] down to len[0], then port[1], port[0].
REQ-017 SHALL spend exactly 8*len cycles in DATA, transmitting each byte MSB first, bytes in transfer order.
REQ-018 SHALL spend exactly 1 cycle in STOP with serOut=1 and done=1, then go to IDLE (or GUARD).
REQ-019 SHALL produce a total frame of 10+8*len cycles from the first START cycle to the STOP cycle inclusive.
REQ-020 SHALL use a one-byte holding register: data_ready=1 only when busy, holding register empty, and bytes accepted < len; it SHALL never request more than len bytes.
REQ-021 SHALL move the holding byte into the bit shifter on the last HDR cycle and on the last bit of each non-final DATA byte; a byte accepted in that same cycle SHALL be loaded directly.
REQ-022 SHALL, when a byte is due at a REQ-021 load point and none is held, transmit 8'h00 for that byte, set underrun, and keep frame timing unchanged; the unsent byte count SHALL still be decremented.
REQ-023 SHALL ignore start, port and len changes while busy.
REQ-024 SHALL hold serOut=1 in IDLE, STOP and GUARD.

Reset
REQ-025 SHALL, on rst asserted (including mid-frame), immediately force state=IDLE, serOut=1, busy=0, done=0, data_ready=0, underrun=0, holding register empty, and all counters to 0.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst deasserts; no partial frame SHALL be resumed.

Configuration
REQ-027 SHALL support macro MSSD_TX_GUARD_EN: when defined, STOP SHALL be followed by exactly 2 GUARD cycles (serOut=1, busy=1) before IDLE; when undefined, STOP SHALL go directly to IDLE, and a start in the cycle after STOP SHALL be accepted.

Verification
REQ-028 SHALL verify: port=2'b10, len=1, 8'hA5 presented at acceptance -> serOut cycles 1..18 = 0, 000001, 10, 10100101, 1; done high in cycle 18 only; underrun=0.
REQ-029 SHALL verify: len=3, bytes 8'h01,8'hFF,8'h3C with data_valid held high -> data_ready accepts exactly 3 bytes; DATA bits = 00000001 11111111 00111100; frame 34 cycles.
REQ-030 SHALL verify: len=2, only first byte 8'h81 supplied -> second byte sent as 8'h00, underrun=1 after the load point, stays set until the next accepted start, which clears it.
REQ-031 SHALL verify: start with len=0 -> busy stays 0, serOut stays 1, data_ready stays 0.
REQ-032 SHALL verify: rst asserted in DATA cycle 5 of len=2 -> serOut=1 and busy=0 immediately; next start sends a complete, correct frame.
REQ-033 SHALL verify: back-to-back frames with start held high -> without MSSD_TX_GUARD_EN the next START begins 2 cycles after STOP (IDLE, then START); with it, 4 cycles after.
